// File: rtl/kpscan_if.sv
// Keypad pin and key-event bundle for kpscan_ctrl.
// master = scan controller, slave = keypad pins / key consumer side.
interface kpscan_if;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input kpr, output kpc, key_code, key_valid, key_held);
  modport slave  (output kpr, input kpc, key_code, key_valid, key_held);
endinterface

// File: rtl/kpscan_ctrl.sv
// 4x4 keypad scanner: column strobing, row synchronisation, press/release debounce and decode.
// Define KPSCAN_REPEAT_EN to add auto-repeat of key_valid while a key stays held.
module kpscan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 20000,
  parameter int unsigned RPT_DLY  = 500000,
  parameter int unsigned RPT_PER  = 100000
) (
  input  logic     clk,
  input  logic     reset,
  kpscan_if.master kp
);

  localparam int unsigned MAX_AB = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int unsigned MAX_CD = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int unsigned MAXV   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TC   = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    rs1_q, rs_q;
  logic [3:0]    rcap_q, rcap_d;
  logic [3:0]    kpc_q, kpc_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [CW-1:0] cnt_q, cnt_d;

`ifdef KPSCAN_REPEAT_EN
  localparam logic [CW-1:0] RPT_TC     = CW'(RPT_DLY - 1);
  localparam logic [CW-1:0] RPT_RELOAD = CW'(RPT_DLY - RPT_PER);
  logic [CW-1:0] rpt_q, rpt_d;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] decode(input logic [3:0] row, input logic [3:0] col);
    logic [3:0] code;
    case ({row, col})
      8'b1110_1110: code = 4'd13;
      8'b1110_1101: code = 4'd15;
      8'b1110_1011: code = 4'd0;
      8'b1110_0111: code = 4'd14;
      8'b1101_1110: code = 4'd12;
      8'b1101_1101: code = 4'd9;
      8'b1101_1011: code = 4'd8;
      8'b1101_0111: code = 4'd7;
      8'b1011_1110: code = 4'd11;
      8'b1011_1101: code = 4'd6;
      8'b1011_1011: code = 4'd5;
      8'b1011_0111: code = 4'd4;
      8'b0111_1110: code = 4'd10;
      8'b0111_1101: code = 4'd3;
      8'b0111_1011: code = 4'd2;
      8'b0111_0111: code = 4'd1;
      default:      code = 4'd0;
    endcase
    return code;
  endfunction

  // cnt doubles as the SCAN dwell counter and the press/release debounce counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcap_d      = rcap_q;
    kpc_d       = kpc_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KPSCAN_REPEAT_EN
    rpt_d       = rpt_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_TC) begin
          cnt_d = '0;
          if (one_low(rs_q)) begin
            rcap_d  = rs_q;
            state_d = ST_DEBOUNCE;
          end else begin
            kpc_d = rot(kpc_q);
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_DEBOUNCE: begin
        if (rs_q != rcap_q) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          key_valid_d = 1'b1;
          key_code_d  = decode(rcap_q, kpc_q);
          key_held_d  = 1'b1;
          state_d     = ST_PRESSED;
          cnt_d       = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PRESSED: begin
        if (rs_q == '1) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
`ifdef KPSCAN_REPEAT_EN
        // Reloading to RPT_DLY-RPT_PER makes later repeats land every RPT_PER cycles.
        else if (rpt_q == RPT_TC) begin
          key_valid_d = 1'b1;
          rpt_d       = RPT_RELOAD;
        end else begin
          rpt_d = sat_inc(rpt_q);
        end
`endif
      end
      ST_RELEASE: begin
        if (rs_q != '1) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == DB_TC) begin
          key_held_d = 1'b0;
          state_d    = ST_SCAN;
          cnt_d      = '0;
          kpc_d      = rot(kpc_q);
`ifdef KPSCAN_REPEAT_EN
          // Repeat timing survives release bounces; cleared only once the key is truly gone.
          rpt_d      = '0;
`endif
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      rs1_q       <= '1;
      rs_q        <= '1;
      rcap_q      <= '1;
      kpc_q       <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KPSCAN_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs1_q       <= kp.kpr;
      rs_q        <= rs1_q;
      rcap_q      <= rcap_d;
      kpc_q       <= kpc_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KPSCAN_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign kp.kpc       = kpc_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_kpscan_ctrl.sv
// Directed bench for kpscan_ctrl with a keypad pin model and a key-event scoreboard.
module tb_kpscan_ctrl;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 8;
  localparam int unsigned RPT_DLY  = 40;
  localparam int unsigned RPT_PER  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_row = 4'b1111;
  logic [3:0] key_col = 4'b1111;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cols[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  bit         prev_valid = 1'b0;

  kpscan_if kp();

  kpscan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row to the strobed column only while that column is driven low.
  assign kp.kpr = (kp.kpc == key_col) ? key_row : 4'b1111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] target);
    int guard = 0;
    while (kp.kpc == target && guard < 64) begin tick(); guard++; end
    while (kp.kpc != target && guard < 64) begin tick(); guard++; end
    if (guard >= 64) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_col: kpc=%b never reached %b", kp.kpc, target);
    end
  endtask

  // Monitor: every strobe pops one expected code.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (kp.key_valid) begin
        check("no_back_to_back", {31'd0, prev_valid}, 32'd0);
        check("held_on_strobe", {31'd0, kp.key_held}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_strobe: got code %0d expected no strobe", kp.key_code);
        end else begin
          check("key_code", {28'd0, kp.key_code}, {28'd0, exp_q.pop_front()});
        end
      end
      prev_valid = kp.key_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    // 1: reset state and idle column rotation
    repeat (3) tick();
    reset = 1'b0;
    check("rst_kpc", {28'd0, kp.kpc}, 32'hE);
    check("rst_code", {28'd0, kp.key_code}, 32'd0);
    check("rst_valid", {31'd0, kp.key_valid}, 32'd0);
    check("rst_held", {31'd0, kp.key_held}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      check("idle_scan_kpc", {28'd0, kp.kpc}, {28'd0, cols[(i / 4) % 4]});
      tick();
    end

    // 2: single press of row 0111 / column 1011 -> code 2
    wait_col(4'b1011);
    exp_q.push_back(4'd2);
    key_col = 4'b1011;
    key_row = 4'b0111;
    repeat (11) tick();
    check("t2_held_pre", {31'd0, kp.key_held}, 32'd0);
    check("t2_valid_pre", {31'd0, kp.key_valid}, 32'd0);
    tick();
    check("t2_valid", {31'd0, kp.key_valid}, 32'd1);
    check("t2_code", {28'd0, kp.key_code}, 32'd2);
    repeat (12) tick();
    check("t2_held_mid", {31'd0, kp.key_held}, 32'd1);
    key_row = 4'b1111;
    repeat (10) tick();
    check("t2_held_rel", {31'd0, kp.key_held}, 32'd1);
    tick();
    check("t2_held_off", {31'd0, kp.key_held}, 32'd0);
    check("t2_kpc_next", {28'd0, kp.kpc}, 32'h7);

    // 3: row chatter during debounce never qualifies and the column stays put
    wait_col(4'b1011);
    key_col = 4'b1011;
    for (int t = 0; t < 36; t++) begin
      key_row = (((t / 3) % 2) == 0) ? 4'b0111 : 4'b1111;
      check("t3_kpc_frozen", {28'd0, kp.kpc}, 32'hB);
      tick();
    end
    key_row = 4'b1111;
    repeat (12) tick();

    // 4: row 1110 / column 1101 -> code 15, release bounces absorbed
    wait_col(4'b1101);
    exp_q.push_back(4'd15);
    key_col = 4'b1101;
    key_row = 4'b1110;
    repeat (12) tick();
    check("t4_valid", {31'd0, kp.key_valid}, 32'd1);
    check("t4_code", {28'd0, kp.key_code}, 32'd15);
    repeat (8) tick();
    for (int j = 0; j < 12; j++) begin
      key_row = ((j % 4) < 2) ? 4'b1111 : 4'b1110;
      tick();
      check("t4_held_bounce", {31'd0, kp.key_held}, 32'd1);
    end
    key_row = 4'b1111;
    repeat (10) tick();
    check("t4_held_rel", {31'd0, kp.key_held}, 32'd1);
    tick();
    check("t4_held_off", {31'd0, kp.key_held}, 32'd0);
    check("t4_kpc_next", {28'd0, kp.kpc}, 32'hB);

    // 5: reset while debouncing row 1101 / column 1110 (code 12)
    wait_col(4'b1110);
    key_col = 4'b1110;
    key_row = 4'b1101;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("t5_kpc", {28'd0, kp.kpc}, 32'hE);
    check("t5_code", {28'd0, kp.key_code}, 32'd0);
    check("t5_valid", {31'd0, kp.key_valid}, 32'd0);
    check("t5_held", {31'd0, kp.key_held}, 32'd0);
    reset = 1'b0;
    exp_q.push_back(4'd12);
    repeat (11) tick();
    check("t5_held_pre", {31'd0, kp.key_held}, 32'd0);
    check("t5_valid_pre", {31'd0, kp.key_valid}, 32'd0);
    tick();
    check("t5_valid", {31'd0, kp.key_valid}, 32'd1);
    check("t5_held", {31'd0, kp.key_held}, 32'd1);
    key_row = 4'b1111;
    repeat (11) tick();
    check("t5_held_off", {31'd0, kp.key_held}, 32'd0);
    check("t5_kpc_next", {28'd0, kp.kpc}, 32'hD);

    // 6: two rows low is not a key
    wait_col(4'b1011);
    key_col = 4'b1011;
    key_row = 4'b1100;
    repeat (4) tick();
    check("t6_kpc_rot1", {28'd0, kp.kpc}, 32'h7);
    repeat (4) tick();
    check("t6_kpc_rot2", {28'd0, kp.kpc}, 32'hE);
    key_row = 4'b1111;
    repeat (8) tick();

`ifdef KPSCAN_REPEAT_EN
    // Auto-repeat: key 1 (row 0111 / column 0111)
    wait_col(4'b0111);
    key_col = 4'b0111;
    key_row = 4'b0111;
    repeat (5) exp_q.push_back(4'd1);
    for (int t = 1; t <= 100; t++) begin
      tick();
      check("rpt_valid", {31'd0, kp.key_valid},
            (t == 12 || t == 52 || t == 62 || t == 72 || t == 82) ? 32'd1 : 32'd0);
      if (t == 88) key_row = 4'b1111;
    end
    check("rpt_held_off", {31'd0, kp.key_held}, 32'd0);
`endif

    repeat (10) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
